// File: rtl/ps2_kb_ctrl.sv
// ps2_kb_ctrl: PS/2 keyboard controller for the CPU bus.
// Resynchronises kclk/kdata and deframes 11-bit PS/2 frames. E0/F0 prefixes are folded
// into one {ext, brk, code} event per key, and events are queued in a FIFO that the CPU
// reads through keyboard_cs.
// Optional build macro: PS2_PARITY_CHECK_EN. When it is defined, frames must have odd
// parity over the 8 data bits plus the parity bit. When it is not defined, the parity bit
// is ignored.
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   kclk, kdata       raw PS/2 pins (asynchronous to clk)
//   keyboard_cs       bus chip-select; qualifies kb_rd and kb_clr
//   kb_rd             pop the FIFO head
//   kb_clr            clear the sticky kb_ovf/kb_ferr flags
//   kb_data           FIFO head {ext, brk, code}; 0 when the FIFO is empty
//   kb_ready          FIFO not empty
//   kb_ovf            sticky: an event was dropped because the FIFO was full
//   kb_ferr           sticky: a frame was aborted (start/stop/parity/timeout)
module ps2_kb_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  input  logic       keyboard_cs,
  input  logic       kb_rd,
  input  logic       kb_clr,
  output logic [9:0] kb_data,
  output logic       kb_ready,
  output logic       kb_ovf,
  output logic       kb_ferr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Pin synchronisers and kclk falling-edge detect; idle line level is 1.
  logic [SYNC_STAGES-1:0] kclk_sync, kdata_sync;
  logic                   kclk_prev;
  logic                   kclk_s, kdata_s, fall_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_sync  <= '1;
      kdata_sync <= '1;
      kclk_prev  <= 1'b1;
    end else begin
      kclk_sync  <= {kclk_sync[SYNC_STAGES-2:0], kclk};
      kdata_sync <= {kdata_sync[SYNC_STAGES-2:0], kdata};
      kclk_prev  <= kclk_s;
    end
  end

  assign kclk_s  = kclk_sync[SYNC_STAGES-1];
  assign kdata_s = kdata_sync[SYNC_STAGES-1];
  assign fall_c  = kclk_prev & ~kclk_s;

  // Frame deserialiser state
  state_t         state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           byte_valid_q, byte_valid_d;
  logic           ferr_set_c;
  logic           frame_ok_c;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign frame_ok_c = ^{shreg_q, par_q};
`else
  assign frame_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  // Next-state logic; the inactivity timeout takes priority over a coincident fall.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    tmo_d        = '0;
    byte_valid_d = 1'b0;
    ferr_set_c   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
`endif
    if (state_q != S_IDLE) tmo_d = fall_c ? '0 : tmo_q + TW'(1);

    if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYC)) begin
      state_d    = S_IDLE;
      ferr_set_c = 1'b1;
      tmo_d      = '0;
    end else if (fall_c) begin
      case (state_q)
        S_IDLE: begin
          if (!kdata_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
        S_DATA: begin
          shreg_d   = {kdata_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = kdata_s;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (kdata_s && frame_ok_c) byte_valid_d = 1'b1;
          else                       ferr_set_c   = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Prefix decoder; shreg_q holds the received byte until the next frame's data bits arrive.
  logic ext_q, brk_q;
  logic push_req_c;

  assign push_req_c = byte_valid_q && (shreg_q != 8'hE0) && (shreg_q != 8'hF0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_valid_q) begin
      if (shreg_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (shreg_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // Event FIFO; the extra pointer MSB distinguishes full from empty.
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty_c, full_c, pop_c, push_c, ovf_set_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_c     = keyboard_cs & kb_rd & ~empty_c;
  assign push_c    = push_req_c & (~full_c | pop_c);
  assign ovf_set_c = push_req_c & full_c & ~pop_c;

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= {ext_q, brk_q, shreg_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + 1'b1;
      if (pop_c)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags; a new error on the same clk as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_ovf  <= 1'b0;
      kb_ferr <= 1'b0;
    end else begin
      if (ovf_set_c)                  kb_ovf <= 1'b1;
      else if (keyboard_cs && kb_clr) kb_ovf <= 1'b0;
      if (ferr_set_c)                 kb_ferr <= 1'b1;
      else if (keyboard_cs && kb_clr) kb_ferr <= 1'b0;
    end
  end

  assign kb_data  = empty_c ? 10'h000 : mem[rd_ptr[AW-1:0]];
  assign kb_ready = ~empty_c;

endmodule

// File: tb/tb_ps2_kb_ctrl.sv
// Self-checking bench for ps2_kb_ctrl: directed scenarios plus a randomized byte stream
// checked against a byte-level event-queue model.
module tb_ps2_kb_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 400;
  localparam int unsigned SYNC  = 2;
  localparam int          H     = 8;   // clk cycles per kclk phase
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, kclk, kdata, cs, rd, clr;
  logic [9:0] kb_data;
  logic       kb_ready, kb_ovf, kb_ferr;

  int tests_run = 0;
  int fails     = 0;

  // Reference model: queue of pending events plus prefix and sticky flags
  logic [9:0] mq[$];
  bit m_ext, m_brk, m_ovf, m_ferr;

  ps2_kb_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata), .keyboard_cs(cs),
    .kb_rd(rd), .kb_clr(clr), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_ovf(kb_ovf), .kb_ferr(kb_ferr)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ferr = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
      else                   m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // Drive the first nbits of a frame: start, 8 data LSB first, odd parity (optionally flipped), stop.
  task automatic send_bits(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); kdata = fr[i];
      repeat (H) @(negedge clk);
      kclk = 1'b0;
      repeat (H) @(negedge clk);
      kclk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par);
    send_bits(b, flip_par, 11);
    repeat (4) @(negedge clk);
    model_byte(b, !(flip_par && PCHK));
  endtask

  // Stop-bit phase with clk-exact visibility: optional pop at edge pop_edge after the kclk fall,
  // and the first edge after which kb_ready is seen high.
  task automatic stop_phase(input int pop_edge, output int ready_edge);
    @(negedge clk); kdata = 1'b1;
    repeat (H) @(negedge clk);
    kclk = 1'b0;
    ready_edge = -1;
    for (int e = 1; e <= H; e++) begin
      if (e == pop_edge) begin cs = 1'b1; rd = 1'b1; end
      @(posedge clk); #1;
      cs = 1'b0; rd = 1'b0;
      if (ready_edge < 0 && kb_ready) ready_edge = e;
      @(negedge clk);
    end
    kclk = 1'b1;
  endtask

  task automatic do_pop(input bit cs_v);
    logic [9:0] exp_d;
    @(negedge clk);
    exp_d = (mq.size() != 0) ? mq[0] : 10'h000;
    tests_run++;
    if (kb_data !== exp_d) begin
      fails++; $display("FAIL pop_data: got %h expected %h", kb_data, exp_d);
    end
    tests_run++;
    if (kb_ready !== (mq.size() != 0)) begin
      fails++; $display("FAIL pop_ready: got %b expected %b", kb_ready, mq.size() != 0);
    end
    cs = cs_v; rd = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    if (cs_v && mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic do_clr(input bit cs_v);
    @(negedge clk);
    cs = cs_v; clr = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; clr = 1'b0;
    if (cs_v) begin m_ovf = 0; m_ferr = 0; end
  endtask

  task automatic check_flags(input string tag);
    tests_run++;
    if (kb_ovf !== m_ovf) begin
      fails++; $display("FAIL %s_ovf: got %b expected %b", tag, kb_ovf, m_ovf);
    end
    tests_run++;
    if (kb_ferr !== m_ferr) begin
      fails++; $display("FAIL %s_ferr: got %b expected %b", tag, kb_ferr, m_ferr);
    end
  endtask

  task automatic drain();
    for (int i = 0; i <= DEPTH && mq.size() != 0; i++) do_pop(1'b1);
    @(negedge clk);
    tests_run++;
    if (kb_ready !== 1'b0) begin
      fails++; $display("FAIL drain_empty: got %b expected 0", kb_ready);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({kb_data, kb_ready, kb_ovf, kb_ferr} !== 13'h0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {kb_data, kb_ready, kb_ovf, kb_ferr});
    end
  endtask

  task automatic test_single();
    int re;
    send_bits(8'h1C, 1'b0, 10);
    stop_phase(0, re);
    model_byte(8'h1C, 1'b1);
    tests_run++;
    if (re != SYNC + 2) begin
      fails++; $display("FAIL single_latency: got edge %0d expected %0d", re, SYNC + 2);
    end
    tests_run++;
    if (kb_data !== 10'h01C) begin
      fails++; $display("FAIL single_data: got %h expected 01c", kb_data);
    end
    do_pop(1'b1);
    @(negedge clk);
    tests_run++;
    if (kb_ready !== 1'b0 || kb_data !== 10'h000) begin
      fails++; $display("FAIL single_after_pop: got ready %b data %h expected 0 000", kb_ready, kb_data);
    end
  endtask

  task automatic test_prefix();
    send_frame(8'hF0, 1'b0);
    tests_run++;
    if (kb_ready !== 1'b0) begin
      fails++; $display("FAIL prefix_f0_alone: got ready %b expected 0", kb_ready);
    end
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (kb_data !== 10'h11C) begin
      fails++; $display("FAIL prefix_break: got %h expected 11c", kb_data);
    end
    do_pop(1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    tests_run++;
    if (kb_ready !== 1'b0) begin
      fails++; $display("FAIL prefix_e0f0_alone: got ready %b expected 0", kb_ready);
    end
    send_frame(8'h75, 1'b0);
    tests_run++;
    if (kb_data !== 10'h375) begin
      fails++; $display("FAIL prefix_ext_break: got %h expected 375", kb_data);
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) send_frame(8'h15 + 8'(i), 1'b0);
    check_flags("ovf_full");
    tests_run++;
    if (kb_ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_set: got %b expected 1", kb_ovf);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (kb_data !== 10'h015 + 10'(i)) begin
        fails++; $display("FAIL ovf_order%0d: got %h expected %h", i, kb_data, 10'h015 + 10'(i));
      end
      do_pop(1'b1);
    end
    drain();
    do_clr(1'b0);
    check_flags("ovf_clr_nocs");
    do_clr(1'b1);
    tests_run++;
    if (kb_ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_clr: got %b expected 0", kb_ovf);
    end
  endtask

  task automatic test_push_pop_full();
    int re;
    for (int i = 0; i < 8; i++) send_frame(8'h15 + 8'(i), 1'b0);
    send_bits(8'h1D, 1'b0, 10);
    stop_phase(SYNC + 2, re);
    void'(mq.pop_front());
    model_byte(8'h1D, 1'b1);
    check_flags("pushpop");
    tests_run++;
    if (kb_data !== 10'h016) begin
      fails++; $display("FAIL pushpop_head: got %h expected 016", kb_data);
    end
    drain();
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1);
    check_flags("parity");
    tests_run++;
    if (kb_data !== (PCHK ? 10'h000 : 10'h01C)) begin
      fails++; $display("FAIL parity_event: got %h expected %h", kb_data, PCHK ? 10'h000 : 10'h01C);
    end
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b0);
    drain();
    check_flags("parity_prefix");
    do_clr(1'b1);
  endtask

  task automatic test_timeout();
    send_bits(8'h1C, 1'b0, 5);
    repeat (TMO / 2) @(negedge clk);
    tests_run++;
    if (kb_ferr !== 1'b0) begin
      fails++; $display("FAIL timeout_early: got %b expected 0", kb_ferr);
    end
    repeat (TMO) @(negedge clk);
    m_ferr = 1;
    check_flags("timeout");
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (kb_data !== 10'h01C) begin
      fails++; $display("FAIL timeout_recover: got %h expected 01c", kb_data);
    end
    drain();
    do_clr(1'b1);
    check_flags("timeout_clr");
  endtask

  task automatic test_reset_mid();
    send_frame(8'h21, 1'b0);
    m_ferr = 1;
    send_frame(8'h1C, 1'b1);
    send_bits(8'h33, 1'b0, 6);
    @(negedge clk); rst = 1'b1; #1;
    tests_run++;
    if ({kb_data, kb_ready, kb_ovf, kb_ferr} !== 13'h0) begin
      fails++; $display("FAIL reset_mid_outputs: got %h expected 0", {kb_data, kb_ready, kb_ovf, kb_ferr});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_frame(8'h1C, 1'b0);
    tests_run++;
    if (kb_data !== 10'h01C) begin
      fails++; $display("FAIL reset_mid_recover: got %h expected 01c", kb_data);
    end
    drain();
    check_flags("reset_mid");
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit flip;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: begin
          b = 8'($urandom);
          if (b == 8'hE0 || b == 8'hF0) b = 8'h1A;
        end
      endcase
      flip = ($urandom_range(0, 7) == 0);
      send_frame(b, flip);
      check_flags("rand");
      if ($urandom_range(0, 2) == 0) do_pop($urandom_range(0, 3) != 0);
    end
    drain();
    check_flags("rand_end");
    do_clr(1'b1);
    check_flags("rand_clr");
  endtask

  initial begin
    rst = 1'b1; kclk = 1'b1; kdata = 1'b1; cs = 1'b0; rd = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    test_single();
    test_prefix();
    test_overflow();
    test_push_pop_full();
    test_parity();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
